console_device: RTL and testbench

Memory-mapped console peripheral that responds to CPU accesses in the device region of the ECLair main bus. The CPU is the bus initiator, through MAR/MDR with active-low select, output-enable and write strobes. This block is the responder. It holds a small TX FIFO drained by an 8N1 serial transmitter and a status register. An optional parallel RX holding register is fed by the simulation host.

---
 rtl/console_device_pkg.sv | 32 +++
 rtl/console_device_if.sv | 19 +
 rtl/console_device_fifo_sync.sv | 61 ++++++
 rtl/console_device.sv | 267 ++++++++++++++++++++++++++
 tb/tb_console_device.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/console_device_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eclair_dev_pkg
//  Purpose  : Shared constants and types for the ECLair console peripheral:
//             register offsets, STATUS bit positions and TX FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package eclair_dev_pkg;

   // Register offsets within the device window (bus_addr[1:0])
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;

   // STATUS register bit positions
   localparam int ST_TX_FULL    = 0;
   localparam int ST_TX_EMPTY   = 1;
   localparam int ST_RX_VALID   = 2;
   localparam int ST_RX_OVERRUN = 3;
   localparam int ST_TX_BUSY    = 4;
   localparam int ST_TX_DROP    = 5;

   // Serial transmitter states
   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/console_device_if.sv
`default_nettype none
// ============================================================================
//  Module   : console_device_if
//  Purpose  : CPU-side bus strobes, address and write data for the console
//             peripheral. The CPU (MAR/MDR side) is the master, the device
//             is the slave. Strobes are active low.
//  Revision : 1.0  initial release
// ============================================================================
interface console_device_if;
   logic       _cs;
   logic       _oe;
   logic       _w;
   logic [1:0] addr;
   logic [7:0] data_in;

   modport master (output _cs, _oe, _w, addr, data_in);
   modport slave  (input  _cs, _oe, _w, addr, data_in);
endinterface
`default_nettype wire

// File: rtl/console_device_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync
//  Purpose  : Single-clock FIFO with show-ahead read data. Pushes into a full
//             FIFO and pops from an empty FIFO are ignored. DEPTH must be a
//             power of two so the pointers wrap naturally.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage array; contents are don't-care after reset since pointers clear
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/console_device.sv
`default_nettype none
// ============================================================================
//  Module   : console_device
//  Purpose  : Memory-mapped console: DATA/STATUS/DIV registers, TX FIFO and
//             an 8N1 serial transmitter. Optional RX holding register is
//             enabled by defining CONSOLE_RX_EN.
//  Revision : 1.0  initial release
// ============================================================================
module console_device
   import eclair_dev_pkg::*;
#(
   parameter int         TX_DEPTH  = 4,
   parameter logic [7:0] DIV_RESET = 8'd3
) (
   input  logic                   clk,
   input  logic                   reset,
   console_device_if.slave        bus,
   output logic [7:0]             data_out,
   output logic                   txd,
   input  logic [7:0]             host_rx_data,
   input  logic                   host_rx_strobe
);
   // Bus history for edge detection
   logic       w_q;
   logic       oe_q;
   logic       cs_q;
   logic [1:0] addr_q;

   logic       write_evt;
   logic       read_end;
   logic       data_wr;
   logic       div_wr;
   logic       data_rd_end;
   logic       status_rd_end;

   logic [7:0] div;
   logic       tx_drop;
   logic [7:0] status;
   logic [7:0] rd_data;

   logic       tx_full;
   logic       tx_empty;
   logic [7:0] fifo_dout;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_overrun;

   tx_state_t  state;
   tx_state_t  state_nx;
   logic [7:0] timer;
   logic [7:0] timer_nx;
   logic [7:0] shift;
   logic [7:0] shift_nx;
   logic [7:0] frame_div;
   logic [7:0] frame_div_nx;
   logic [2:0] bit_idx;
   logic [2:0] bit_idx_nx;
   logic       bit_end;
   logic       start_frame;
   logic       pop;
   logic       txd_nx;
   logic       tx_busy;

   // Keep previous-cycle copies of the bus strobes and address
   always_ff @(posedge clk) begin
      if (reset) begin
         w_q    <= 1'b1;
         oe_q   <= 1'b1;
         cs_q   <= 1'b1;
         addr_q <= 2'd0;
      end else begin
         w_q    <= bus._w;
         oe_q   <= bus._oe;
         cs_q   <= bus._cs;
         addr_q <= bus.addr;
      end
   end

   // A held write strobe counts once; read side effects wait for strobe release
   assign write_evt     = !bus._cs && !bus._w && w_q;
   assign read_end      = bus._oe && !oe_q && !cs_q;
   assign data_wr       = write_evt && (bus.addr == REG_DATA);
   assign div_wr        = write_evt && (bus.addr == REG_DIV);
   assign data_rd_end   = read_end && (addr_q == REG_DATA);
   assign status_rd_end = read_end && (addr_q == REG_STATUS);

   fifo_sync #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (data_wr),
      .push_data (bus.data_in),
      .pop       (pop),
      .pop_data  (fifo_dout),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   // Baud divisor register
   always_ff @(posedge clk) begin
      if (reset) begin
         div <= DIV_RESET;
      end else if (div_wr) begin
         div <= bus.data_in;
      end
   end

   // Sticky drop flag; a new drop in the same cycle as the clear wins
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_drop <= 1'b0;
      end else begin
         if (status_rd_end)        tx_drop <= 1'b0;
         if (data_wr && tx_full)   tx_drop <= 1'b1;
      end
   end

`ifdef CONSOLE_RX_EN
   logic rx_kept;

   // A DATA read-end frees the holding register before a same-cycle strobe
   assign rx_kept = rx_valid && !data_rd_end;

   // RX holding register with valid and sticky overrun flags
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_valid <= rx_kept;
         if (status_rd_end) rx_overrun <= 1'b0;
         if (host_rx_strobe) begin
            if (rx_kept) begin
               rx_overrun <= 1'b1;
            end else begin
               rx_data  <= host_rx_data;
               rx_valid <= 1'b1;
            end
         end
      end
   end
`else
   logic unused_rx;

   assign rx_data    = 8'h00;
   assign rx_valid   = 1'b0;
   assign rx_overrun = 1'b0;
   assign unused_rx  = ^{host_rx_data, host_rx_strobe, data_rd_end};
`endif

   assign bit_end = (timer == 8'd0);
   assign tx_busy = (state != TX_IDLE);

   // Transmitter next-state: one bit period is frame_div+1 clocks
   always_comb begin
      state_nx     = state;
      timer_nx     = timer;
      shift_nx     = shift;
      frame_div_nx = frame_div;
      bit_idx_nx   = bit_idx;
      start_frame  = 1'b0;
      pop          = 1'b0;
      txd_nx       = 1'b1;

      case (state)
         TX_IDLE: begin
            start_frame = !tx_empty;
         end
         TX_START: begin
            if (bit_end) begin
               state_nx   = TX_DATA;
               bit_idx_nx = 3'd0;
               timer_nx   = frame_div;
            end else begin
               timer_nx = timer - 8'd1;
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               timer_nx = frame_div;
               if (bit_idx == 3'd7) begin
                  state_nx = TX_STOP;
               end else begin
                  bit_idx_nx = bit_idx + 3'd1;
                  shift_nx   = {1'b0, shift[7:1]};
               end
            end else begin
               timer_nx = timer - 8'd1;
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               // Chain straight into the next frame so there is no idle gap
               start_frame = !tx_empty;
               if (tx_empty) state_nx = TX_IDLE;
            end else begin
               timer_nx = timer - 8'd1;
            end
         end
         default: state_nx = TX_IDLE;
      endcase

      // Divisor is captured per frame so mid-frame DIV writes wait a frame
      if (start_frame) begin
         pop          = 1'b1;
         state_nx     = TX_START;
         shift_nx     = fifo_dout;
         frame_div_nx = div;
         timer_nx     = div;
      end

      case (state_nx)
         TX_START: txd_nx = 1'b0;
         TX_DATA:  txd_nx = shift_nx[0];
         default:  txd_nx = 1'b1;
      endcase
   end

   // Transmitter state register; txd is registered to stay glitch free
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= TX_IDLE;
         timer     <= 8'd0;
         shift     <= 8'd0;
         frame_div <= 8'd0;
         bit_idx   <= 3'd0;
         txd       <= 1'b1;
      end else begin
         state     <= state_nx;
         timer     <= timer_nx;
         shift     <= shift_nx;
         frame_div <= frame_div_nx;
         bit_idx   <= bit_idx_nx;
         txd       <= txd_nx;
      end
   end

   // STATUS assembly; bits 7:6 read as zero
   always_comb begin
      status                = 8'h00;
      status[ST_TX_FULL]    = tx_full;
      status[ST_TX_EMPTY]   = tx_empty;
      status[ST_RX_VALID]   = rx_valid;
      status[ST_RX_OVERRUN] = rx_overrun;
      status[ST_TX_BUSY]    = tx_busy;
      status[ST_TX_DROP]    = tx_drop;
   end

   // Read mux, driven onto the bus only while selected and output-enabled
   always_comb begin
      rd_data = 8'h00;
      case (bus.addr)
         REG_DATA:   rd_data = rx_data;
         REG_STATUS: rd_data = status;
         REG_DIV:    rd_data = div;
         default:    rd_data = 8'h00;
      endcase
   end

   assign data_out = (!bus._cs && !bus._oe) ? rd_data : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_console_device.sv
`default_nettype none
// ============================================================================
//  Module   : tb_console_device
//  Purpose  : Self-checking bench for console_device. Directed register and
//             waveform checks followed by random bus/host traffic compared
//             against a frame-level reference model. RX checks are active
//             when CONSOLE_RX_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_console_device;
   localparam int         TX_DEPTH  = 4;
   localparam logic [7:0] DIV_RESET = 8'd3;

   logic       clk;
   logic       reset;
   logic [7:0] host_rx_data;
   logic       host_rx_strobe;
   wire  [7:0] data_out;
   wire        txd;

   int n_vectors;
   int n_miscompares;

   console_device_if bus();

   console_device #(
      .TX_DEPTH  (TX_DEPTH),
      .DIV_RESET (DIV_RESET)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus),
      .data_out       (data_out),
      .txd            (txd),
      .host_rx_data   (host_rx_data),
      .host_rx_strobe (host_rx_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   logic [7:0] q[$];
   bit         m_busy;
   int         m_rem, m_total, m_fdiv;
   logic [7:0] m_byte;
   logic [7:0] m_div;
   bit         m_valid, m_over, m_drop;
   logic [7:0] m_rx;
   logic       m_w_q, m_oe_q, m_cs_q;
   logic [1:0] m_addr_q;

   task automatic model_step();
      bit we, re, full_pre, done;
      if (reset) begin
         q.delete();
         m_busy = 0; m_rem = 0; m_total = 0; m_fdiv = 0; m_byte = 8'h00;
         m_div = DIV_RESET; m_valid = 0; m_over = 0; m_drop = 0; m_rx = 8'h00;
         m_w_q = 1'b1; m_oe_q = 1'b1; m_cs_q = 1'b1; m_addr_q = 2'd0;
         return;
      end
      we       = !bus._cs && !bus._w && m_w_q;
      re       = bus._oe && !m_oe_q && !m_cs_q;
      full_pre = (q.size() == TX_DEPTH);
      done     = 0;
      if (m_busy) begin
         m_rem--;
         done = (m_rem == 0);
      end
      if ((!m_busy || done) && q.size() != 0) begin
         m_byte  = q.pop_front();
         m_fdiv  = int'(m_div);
         m_total = 10 * (m_fdiv + 1);
         m_rem   = m_total;
         m_busy  = 1;
      end else if (done) begin
         m_busy = 0;
      end
      if (re && m_addr_q == 2'd1) begin
         m_drop = 0;
         m_over = 0;
      end
`ifdef CONSOLE_RX_EN
      if (re && m_addr_q == 2'd0) m_valid = 0;
      if (host_rx_strobe) begin
         if (m_valid) m_over = 1;
         else begin
            m_rx    = host_rx_data;
            m_valid = 1;
         end
      end
`endif
      if (we && bus.addr == 2'd0) begin
         if (full_pre) m_drop = 1;
         else          q.push_back(bus.data_in);
      end
      if (we && bus.addr == 2'd2) m_div = bus.data_in;
      m_w_q = bus._w; m_oe_q = bus._oe; m_cs_q = bus._cs; m_addr_q = bus.addr;
   endtask

   function automatic logic model_txd();
      int slot;
      if (!m_busy) return 1'b1;
      slot = (m_total - m_rem) / (m_fdiv + 1);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return m_byte[slot-1];
      return 1'b1;
   endfunction

   function automatic logic [7:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return m_rx;
         2'd1:    return {2'b00, m_drop, m_busy, m_over, m_valid,
                          (q.size() == 0), (q.size() == TX_DEPTH)};
         2'd2:    return m_div;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk) model_step();

   // Serial line is compared against the model every cycle
   always @(negedge clk) check("txd", txd, model_txd());

   // ---------------- bus tasks (called at a negedge) ----------------
   task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int hold);
      bus._cs = 1'b0; bus._w = 1'b0; bus.addr = a; bus.data_in = d;
      repeat (hold) @(negedge clk);
      bus._cs = 1'b1; bus._w = 1'b1;
      @(negedge clk);
   endtask

   task automatic bus_read(input logic [1:0] a, input bit co, input logic [7:0] cod,
                           output logic [7:0] v);
      bus._cs = 1'b0; bus._oe = 1'b0; bus.addr = a;
      @(negedge clk);
      v = data_out;
      check("rd_model", v, model_read(a));
      bus._cs = 1'b1; bus._oe = 1'b1;
      host_rx_strobe = co; host_rx_data = cod;
      @(negedge clk);
      host_rx_strobe = 1'b0;
   endtask

   task automatic host_pulse(input logic [7:0] d);
      host_rx_strobe = 1'b1; host_rx_data = d;
      @(negedge clk);
      host_rx_strobe = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] v;
      logic [7:0] pat;
      logic       e;
      bit         any_low;
      int         op;

      n_vectors = 0; n_miscompares = 0;
      reset = 1'b1;
      bus._cs = 1'b1; bus._oe = 1'b1; bus._w = 1'b1; bus.addr = 2'd0; bus.data_in = 8'h00;
      host_rx_strobe = 1'b0; host_rx_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("rst_txd", txd, 1'b1);
      bus_read(2'd1, 0, 8'h00, v); check("rst_status", v, 8'h02);
      bus_read(2'd2, 0, 8'h00, v); check("rst_div", v, 8'h03);
      bus_read(2'd3, 0, 8'h00, v); check("reg3_zero", v, 8'h00);
      bus_write(2'd3, 8'h5A, 1);
      bus_read(2'd3, 0, 8'h00, v); check("reg3_wr_ignored", v, 8'h00);

      // A5 waveform: idle, then start, LSB-first data, stop, 4 clocks per bit
      pat = 8'hA5;
      bus._cs = 1'b0; bus._w = 1'b0; bus.addr = 2'd0; bus.data_in = pat;
      @(negedge clk);
      check("a5_pre", txd, 1'b1);
      bus._cs = 1'b1; bus._w = 1'b1;
      for (int k = 1; k <= 41; k++) begin
         int slot;
         @(negedge clk);
         slot = (k - 1) / 4;
         if (slot == 0)      e = 1'b0;
         else if (slot <= 8) e = pat[slot-1];
         else                e = 1'b1;
         check("a5_bit", txd, e);
      end
      bus_read(2'd1, 0, 8'h00, v); check("a5_done_status", v, 8'h02);

      // Held write strobe queues exactly one byte
      bus_write(2'd2, 8'hFF, 1);
      bus_write(2'd0, 8'h77, 6);
      bus_read(2'd1, 0, 8'h00, v); check("hold_once", v, 8'h12);
      do_reset(1);

      // FIFO fill, drop, and drop clear with a stalled transmitter
      bus_write(2'd2, 8'hFF, 1);
      for (int i = 1; i <= 5; i++) bus_write(2'd0, 8'(i), 1);
      bus_read(2'd1, 0, 8'h00, v); check("fill_full", v, 8'h11);
      bus_write(2'd0, 8'h06, 1);
      bus_read(2'd1, 0, 8'h00, v); check("drop_set", v, 8'h31);
      bus_read(2'd1, 0, 8'h00, v); check("drop_cleared", v, 8'h11);

      // Reset mid-frame aborts transmission
      check("midframe_low", txd, 1'b0);
      do_reset(1);
      check("abort_txd", txd, 1'b1);
      bus_read(2'd1, 0, 8'h00, v); check("abort_status", v, 8'h02);
      any_low = 0;
      repeat (300) begin
         @(negedge clk);
         if (txd !== 1'b1) any_low = 1;
      end
      check("abort_quiet", 16'(any_low), 16'h0);

`ifdef CONSOLE_RX_EN
      host_pulse(8'h3C);
      bus_read(2'd1, 0, 8'h00, v); check("rx_valid", v, 8'h06);
      bus_read(2'd0, 0, 8'h00, v); check("rx_data", v, 8'h3C);
      bus_read(2'd1, 0, 8'h00, v); check("rx_cleared", v, 8'h02);
      host_pulse(8'h11);
      host_pulse(8'h22);
      bus_read(2'd1, 0, 8'h00, v); check("rx_overrun", v, 8'h0E);
      bus_read(2'd0, 0, 8'h00, v); check("rx_first_kept", v, 8'h11);
      bus_read(2'd1, 0, 8'h00, v); check("rx_ovr_cleared", v, 8'h02);
      host_pulse(8'h55);
      bus_read(2'd0, 1, 8'h66, v); check("rx_coinc_old", v, 8'h55);
      bus_read(2'd1, 0, 8'h00, v); check("rx_coinc_status", v, 8'h06);
      bus_read(2'd0, 0, 8'h00, v); check("rx_coinc_new", v, 8'h66);
`else
      host_pulse(8'h3C);
      bus_read(2'd1, 0, 8'h00, v); check("norx_status", v, 8'h02);
      bus_read(2'd0, 0, 8'h00, v); check("norx_data", v, 8'h00);
`endif

      // Random traffic against the model
      do_reset(2);
      for (int it = 0; it < 400; it++) begin
         op = int'($urandom_range(0, 9));
         case (op)
            0, 1, 2: bus_write(2'd0, 8'($urandom), int'($urandom_range(1, 3)));
            3:       bus_write(2'd2, 8'($urandom_range(0, 3)), 1);
            4:       bus_write(2'd3, 8'($urandom), 1);
            5, 6:    bus_read(2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                              8'($urandom), v);
            7:       host_pulse(8'($urandom));
            default: repeat ($urandom_range(1, 25)) @(negedge clk);
         endcase
      end
      repeat (200) @(negedge clk);
      bus_read(2'd1, 0, 8'h00, v);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end
endmodule
`default_nettype wire
